// File: rtl/reg_univ_pkg.sv
// reg_univ_pkg: shared constants for the universal register.
//   MODE_W          width of the mode select bus
//   MODE_HOLD..DEC  operation encodings for the mode input
package reg_univ_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROTL = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROTR = 3'b101;
   localparam logic [MODE_W-1:0] MODE_INC  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/reg_univ_pr_ps.sv
// reg_univ_pr_ps: W-bit universal register with synchronous clear (ps),
// synchronous preset (pr), enable, and hold/load/shift/rotate/inc/dec modes.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears q, so, co)
//   en     operation enable (0 = hold)
//   pr     synchronous preset to PRESET_VAL
//   ps     synchronous clear, wins over pr
//   mode   operation select (see reg_univ_pkg)
//   d      parallel load data
//   sin    serial input for shifts
//   q      register contents
//   so     bit shifted/rotated out on the last edge
//   co     wrap flag of the last inc/dec
module reg_univ_pr_ps
   import reg_univ_pkg::*;
#(
   parameter int unsigned   W          = 8,
   parameter logic [W-1:0]  PRESET_VAL = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              pr,
   input  logic              ps,
   input  logic [MODE_W-1:0] mode,
   input  logic [W-1:0]      d,
   input  logic              sin,
   output logic [W-1:0]      q,
   output logic              so,
   output logic              co
);

   // Shift/rotate results are taken from a W+1 bit concatenation so the
   // same expressions stay legal and correct for W=1.
   logic [W:0]   shl_ext;
   logic [W:0]   shr_ext;
   logic [W:0]   rotl_ext;
   logic [W:0]   rotr_ext;

   logic [W-1:0] q_nx;
   logic         so_nx;
   logic         co_nx;

   assign shl_ext  = {q, sin};
   assign shr_ext  = {sin, q};
   assign rotl_ext = {q, q[W-1]};
   assign rotr_ext = {q[0], q};

   always_comb begin
      q_nx  = q;
      so_nx = 1'b0;
      co_nx = 1'b0;
      case (mode)
         MODE_HOLD: q_nx = q;
         MODE_LOAD: q_nx = d;
         MODE_SHL: begin
            q_nx  = shl_ext[W-1:0];
            so_nx = q[W-1];
         end
         MODE_SHR: begin
            q_nx  = shr_ext[W:1];
            so_nx = q[0];
         end
         MODE_ROTL: begin
            q_nx  = rotl_ext[W-1:0];
            so_nx = q[W-1];
         end
         MODE_ROTR: begin
            q_nx  = rotr_ext[W:1];
            so_nx = q[0];
         end
         MODE_INC: begin
            q_nx  = q + W'(1);
            co_nx = &q;
         end
         MODE_DEC: begin
            q_nx  = q - W'(1);
            co_nx = ~|q;
         end
         default: q_nx = q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q  <= '0;
         so <= 1'b0;
         co <= 1'b0;
      end else if (ps) begin
         q  <= '0;
         so <= 1'b0;
         co <= 1'b0;
      end else if (pr) begin
         q  <= PRESET_VAL;
         so <= 1'b0;
         co <= 1'b0;
      end else if (!en) begin
         so <= 1'b0;
         co <= 1'b0;
      end else begin
         q  <= q_nx;
         so <= so_nx;
         co <= co_nx;
      end
   end

endmodule
